// File: rtl/aes_arbiter.sv
// Two-requester round-robin front end for a single AES core.
// Launches one core operation at a time, with a WAIT-state timeout that aborts a hung core.
module aes_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [127:0] plain0,
    input  logic [127:0] plain1,
    input  logic [127:0] key0,
    input  logic [127:0] key1,
    output logic         aes_start,
    output logic [127:0] aes_plain,
    output logic [127:0] aes_key,
    input  logic         aes_done,
    input  logic [127:0] aes_cipher,
    output logic         rsp_valid0,
    output logic         rsp_valid1,
    output logic         rsp_err,
    output logic [127:0] rsp_cipher,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_q, last_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [127:0]   plain_q, plain_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   cipher_q, cipher_d;
    logic           err_q, err_d;
    logic           arb_grant;

    // On a tie the requester that was not served last wins.
    always_comb begin
        arb_grant = 1'b0;
        if (req0 && req1) begin
            arb_grant = ~last_q;
        end else if (req1) begin
            arb_grant = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        plain_d  = plain_q;
        key_d    = key_q;
        cipher_d = cipher_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d = arb_grant;
                    plain_d = arb_grant ? plain1 : plain0;
                    key_d   = arb_grant ? key1 : key0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = 16'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion landing on the timeout cycle still counts as success.
                if (aes_done) begin
                    cipher_d = aes_cipher;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (cnt_q + 16'd1 == TIMEOUT) begin
                    cnt_d    = cnt_q + 16'd1;
                    cipher_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 16'd0;
            plain_q  <= '0;
            key_q    <= '0;
            cipher_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            plain_q  <= plain_d;
            key_q    <= key_d;
            cipher_q <= cipher_d;
            err_q    <= err_d;
        end
    end

    assign aes_start  = (state_q == ST_LAUNCH);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid0 = (state_q == ST_RESP) && !grant_q;
    assign rsp_valid1 = (state_q == ST_RESP) && grant_q;
    assign rsp_err    = err_q;
    assign rsp_cipher = cipher_q;
    assign aes_plain  = plain_q;
    assign aes_key    = key_q;

endmodule

// File: tb/tb_aes_arbiter.sv
// Scoreboard bench for aes_arbiter: a behavioural core model answers launches and a
// negedge monitor pops expected responses as the arbiter produces them.
module tb_aes_arbiter;

    localparam logic [127:0] FIPS_P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_C = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [127:0] plain0 = '0, plain1 = '0, key0 = '0, key1 = '0;
    logic         aes_start;
    logic [127:0] aes_plain, aes_key;
    logic         aes_done;
    logic         core_done = 1'b0, stray_done = 1'b0;
    logic [127:0] aes_cipher = '0;
    logic         rsp_valid0, rsp_valid1, rsp_err, busy;
    logic [127:0] rsp_cipher;

    typedef struct packed {
        logic [1:0]   vld;
        logic         err;
        logic [127:0] cipher;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, t_req = 0, exp_lat = 0;
    int   rsp_cnt = 0, start_cnt = 0;
    int   core_delay = 0;

    assign aes_done = core_done | stray_done;

    aes_arbiter #(.TIMEOUT(16'd20)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .plain0(plain0), .plain1(plain1), .key0(key0), .key1(key1),
        .aes_start(aes_start), .aes_plain(aes_plain), .aes_key(aes_key),
        .aes_done(aes_done), .aes_cipher(aes_cipher),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_err(rsp_err), .rsp_cipher(rsp_cipher), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
        if (p == FIPS_P && k == FIPS_K) return FIPS_C;
        return p ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_cnt < n && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (rsp_cnt < n) check("rsp_wait_timeout", 128'(rsp_cnt), 128'(n));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Core model: done pulses in the core_delay-th WAIT cycle; delay 0 means never.
    initial forever begin
        logic [127:0] cp, ck;
        int d;
        @(negedge clk);
        if (aes_start && core_delay != 0) begin
            cp = aes_plain;
            ck = aes_key;
            d  = core_delay;
            repeat (d) @(posedge clk);
            #1;
            core_done  = 1'b1;
            aes_cipher = core_fn(cp, ck);
            @(posedge clk);
            #1;
            core_done = 1'b0;
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && !busy && (req0 || req1)) t_req = cyc;
        if (aes_start) start_cnt++;
        if (rsp_valid0 || rsp_valid1) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 128'({rsp_valid1, rsp_valid0}), 128'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_id", 128'({rsp_valid1, rsp_valid0}), 128'(e.vld));
                check("rsp_err", 128'(rsp_err), 128'(e.err));
                check("rsp_cipher", rsp_cipher, e.cipher);
                if (exp_lat != 0) check("latency", 128'(cyc - t_req + 1), 128'(exp_lat));
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_ctrl", 128'({aes_start, rsp_valid0, rsp_valid1, rsp_err, busy}), 128'(0));
        check("rst_cipher", rsp_cipher, 128'(0));
        check("rst_operands", {aes_plain ^ aes_key}, 128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single request with the FIPS-197 vector, 11-cycle core
        core_delay = 11;
        exp_lat    = 14;
        start_cnt  = 0;
        sb.push_back('{2'b01, 1'b0, FIPS_C});
        #1;
        plain0 = FIPS_P;
        key0   = FIPS_K;
        req0   = 1'b1;
        wait_rsp(1);
        req0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("single_starts", 128'(start_cnt), 128'(1));
        check("single_hold_cipher", rsp_cipher, FIPS_C);
        check("single_idle", 128'(busy), 128'(0));

        // Tie straight after reset: grants alternate starting with requester 0
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        core_delay = 3;
        exp_lat    = 6;
        start_cnt  = 0;
        rsp_cnt    = 0;
        plain0 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
        key0   = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
        plain1 = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
        key1   = 128'hf0e1_d2c3_b4a5_9687_7869_5a4b_3c2d_1e0f;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back('{2'b01, 1'b0, core_fn(plain0, key0)});
            else            sb.push_back('{2'b10, 1'b0, core_fn(plain1, key1)});
        end
        req0 = 1'b1;
        req1 = 1'b1;
        wait_rsp(4);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("tie_starts", 128'(start_cnt), 128'(4));
        check("tie_sb_empty", 128'(sb.size()), 128'(0));

        // Core never answers: timeout after 20 WAIT cycles
        core_delay = 0;
        exp_lat    = 23;
        rsp_cnt    = 0;
        sb.push_back('{2'b01, 1'b1, 128'(0)});
        req0 = 1'b1;
        wait_rsp(1);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("timeout_err_held", 128'(rsp_err), 128'(1));
        check("timeout_cipher_held", rsp_cipher, 128'(0));

        // Done on the final WAIT cycle wins over timeout; req1 drops mid-flight
        core_delay = 20;
        exp_lat    = 23;
        rsp_cnt    = 0;
        sb.push_back('{2'b10, 1'b0, core_fn(plain1, key1)});
        req1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 req1 = 1'b0;
        wait_rsp(1);
        repeat (2) @(posedge clk);

        // Stray done while idle produces nothing
        #1 stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stray_busy", 128'(busy), 128'(0));
        check("stray_no_rsp", 128'(rsp_cnt), 128'(1));

        // Reset in WAIT: everything clears, held req is re-run from scratch
        core_delay = 0;
        exp_lat    = 0;
        start_cnt  = 0;
        req0 = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 128'({aes_start, rsp_valid0, rsp_valid1, rsp_err, busy}), 128'(0));
        check("midrst_cipher", rsp_cipher, 128'(0));
        check("midrst_plain", aes_plain, 128'(0));
        check("midrst_key", aes_key, 128'(0));
        repeat (3) @(posedge clk);
        core_delay = 5;
        exp_lat    = 8;
        start_cnt  = 0;
        rsp_cnt    = 0;
        sb.push_back('{2'b01, 1'b0, core_fn(plain0, key0)});
        #1 rst_n = 1'b1;
        wait_rsp(1);
        req0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_starts", 128'(start_cnt), 128'(1));
        check("midrst_rsp_cnt", 128'(rsp_cnt), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1000, giving the maximum WAIT-state cycles before a transaction is aborted; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1, the single system clock; all flops are on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0 and req1, input, 1 each, requester N asks for one encryption.
REQ-005 SHALL have ports plain0 and plain1, input, 128 each, requester N plaintext.
REQ-006 SHALL have ports key0 and key1, input, 128 each, requester N key.
REQ-007 SHALL have port aes_start, output, 1, one-cycle launch pulse to the AES core.
REQ-008 SHALL have ports aes_plain and aes_key, output, 128 each, operands to the core.
REQ-009 SHALL have port aes_done, input, 1, core completion indication.
REQ-010 SHALL have port aes_cipher, input, 128, core result.
REQ-011 SHALL have ports rsp_valid0 and rsp_valid1, output, 1 each, one-cycle response pulse to requester N.
REQ-012 SHALL have port rsp_err, output, 1, qualifies rsp_validN; 1 means timeout.
REQ-013 SHALL have port rsp_cipher, output, 128, result presented with rsp_validN.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, LAUNCH, WAIT and RESP.
REQ-016 SHALL, in IDLE with any req asserted, latch the grant index plus plainN/keyN into aes_plain/aes_key and move to LAUNCH.
REQ-017 SHALL arbitrate round-robin: a lone request wins; when both are asserted, the requester not granted last wins; the last-grant pointer resets to 1, so req0 wins the first tie.
REQ-018 SHALL assert aes_start for exactly the LAUNCH cycle, then move to WAIT with the timeout counter cleared.
REQ-019 SHALL, in WAIT on aes_done=1, capture aes_cipher into rsp_cipher and move to RESP.
REQ-020 SHALL, in WAIT, increment the 16-bit counter each cycle without aes_done; on reaching TIMEOUT, load rsp_cipher=0, set the error flag and move to RESP.
REQ-021 SHALL, in RESP, pulse rsp_valid of the granted requester only, drive rsp_err from the error flag, update the last-grant pointer and return to IDLE.
REQ-022 SHALL keep rsp_cipher and rsp_err stable from RESP until the next RESP.
REQ-023 SHALL give a latency of 3 + D cycles from req sampled in IDLE to rsp_valid, where D is the number of WAIT cycles (D>=1).
REQ-024 SHALL ignore aes_done outside WAIT.
REQ-025 SHALL ignore requester inputs outside IDLE; a req deasserted mid-transaction does not abort it, and the response is still issued.
REQ-026 SHALL handle aes_done arriving on the same cycle the counter reaches TIMEOUT as success; done has priority.
REQ-027 SHALL not re-grant in the RESP cycle; a still-asserted req is re-evaluated in the following IDLE cycle, so back-to-back transactions are separated by one IDLE cycle.
REQ-028 SHALL require requesters to hold reqN, plainN and keyN until their rsp_validN; a held req after the response starts a new transaction.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously force: state IDLE, aes_start=0, rsp_valid0=0, rsp_valid1=0, rsp_err=0, busy=0, rsp_cipher=0, aes_plain=0, aes_key=0, counter=0, last-grant=1.
REQ-030 SHALL, on reset asserted mid-transaction, emit no response for the aborted transaction; after release, a held req is re-arbitrated from IDLE.

Verification
REQ-031 Single request: req0 with plain0=3243f6a8885a308d313198a2e0370734, key0=2b7e151628aed2a6abf7158809cf4f3c, core model done after 11 cycles -> one aes_start pulse; rsp_valid0 pulse with rsp_cipher=3925841d02dc09fbdc118597196a0b32 and rsp_err=0; latency 14 cycles.
REQ-032 Tie after reset: req0 and req1 asserted together and held -> grant order 0,1,0,1; each response pulses only the matching rsp_validN.
REQ-033 Timeout: TIMEOUT=20, core never asserts done -> rsp_valid pulse 23 cycles after req, with rsp_err=1 and rsp_cipher=0.
REQ-034 Done/timeout collision: done on the TIMEOUT-th WAIT cycle -> rsp_err=0 and rsp_cipher equals the core output.
REQ-035 Stray done and mid-operation reset: aes_done pulsed in IDLE -> no response; rst_n low during WAIT -> all outputs 0 immediately and no rsp_valid pulse after release until a new full transaction completes.
